mac_vec_pe: RTL

MAC_VEC_PE -- requirements
Module: mac_vec_pe

---
 rtl/cnn_acc_pkg.sv | 19 +
 rtl/mac_vec_dot.sv | 54 +++++
 rtl/mac_vec_pe.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the CNN accelerator PE array: default widths and the
// weight-swap state type.
package cnn_acc_pkg;

  localparam int DEF_LANES      = 4;
  localparam int DEF_A_BITWIDTH = 8;
  localparam int DEF_W_BITWIDTH = 8;
  localparam int DEF_P_BITWIDTH = 24;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mac_vec_dot.sv
// Combinational lane multipliers plus adder tree; each product is formed at
// A_BITWIDTH+W_BITWIDTH bits and sign/zero-extended to SUM_W before summing.
module mac_vec_dot
  import cnn_acc_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int A_BITWIDTH = DEF_A_BITWIDTH,
  parameter int W_BITWIDTH = DEF_W_BITWIDTH,
  parameter int SUM_W      = DEF_P_BITWIDTH,
  parameter int SIGNED     = 1
) (
  input  logic        [LANES*A_BITWIDTH-1:0] a_vec,
  input  logic        [LANES*W_BITWIDTH-1:0] w_vec,
  output logic signed [SUM_W-1:0]            dot
);

  localparam int PROD_W = A_BITWIDTH + W_BITWIDTH;

  logic signed [SUM_W-1:0] prod_ext [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [A_BITWIDTH-1:0] a_i;
    logic [W_BITWIDTH-1:0] w_i;

    assign a_i = a_vec[i*A_BITWIDTH +: A_BITWIDTH];
    assign w_i = w_vec[i*W_BITWIDTH +: W_BITWIDTH];

    if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] a_x;
      logic signed [PROD_W-1:0] w_x;
      logic signed [PROD_W-1:0] prod;
      assign a_x         = PROD_W'($signed(a_i));
      assign w_x         = PROD_W'($signed(w_i));
      assign prod        = a_x * w_x;
      assign prod_ext[i] = SUM_W'(prod);
    end else begin : g_unsigned
      logic [PROD_W-1:0] a_x;
      logic [PROD_W-1:0] w_x;
      logic [PROD_W-1:0] prod;
      assign a_x         = PROD_W'(a_i);
      assign w_x         = PROD_W'(w_i);
      assign prod        = a_x * w_x;
      assign prod_ext[i] = SUM_W'(prod);
    end
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + prod_ext[i];
    end
  end

endmodule

// File: rtl/mac_vec_pe.sv
// Vector MAC processing element with double-buffered weights and forwarding.
// Define MAC_VEC_PE_SAT_EN to clamp P_out on overflow and enable sat_flag.
module mac_vec_pe
  import cnn_acc_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int A_BITWIDTH = DEF_A_BITWIDTH,
  parameter int W_BITWIDTH = DEF_W_BITWIDTH,
  parameter int P_BITWIDTH = DEF_P_BITWIDTH,
  parameter int SIGNED     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        switch_in,
  output logic                        switch_out,
  input  logic                        W_en,
  input  logic [W_BITWIDTH-1:0]       W_in,
  output logic [W_BITWIDTH-1:0]       W_out,
  output logic                        W_ready,
  input  logic                        A_en,
  input  logic [LANES*A_BITWIDTH-1:0] A_in,
  output logic [LANES*A_BITWIDTH-1:0] A_out,
  output logic                        A_ready,
  input  logic [P_BITWIDTH-1:0]       P_in,
  output logic [P_BITWIDTH-1:0]       P_out,
  output logic                        shadow_full,
  output logic                        sat_flag
);

  localparam int PROD_W = A_BITWIDTH + W_BITWIDTH;
`ifdef MAC_VEC_PE_SAT_EN
  // Headroom so the true sum is exact and overflow can be detected.
  localparam int SUM_W = max_int(P_BITWIDTH, PROD_W) + $clog2(LANES + 1) + 1;
`else
  localparam int SUM_W = max_int(P_BITWIDTH, PROD_W);
`endif
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  swap_state_t                   state;
  logic [CNT_W-1:0]              lane_cnt;
  logic [LANES*W_BITWIDTH-1:0]   w_shadow;
  logic [LANES*W_BITWIDTH-1:0]   w_active;
  logic signed [SUM_W-1:0]       dot_sum;
  logic signed [SUM_W-1:0]       p_ext;
  logic signed [SUM_W-1:0]       total;
  logic [P_BITWIDTH-1:0]         p_next;

`ifdef MAC_VEC_PE_SAT_EN
  localparam logic signed [SUM_W-1:0] P_MAX = (SIGNED != 0) ?
    {{(SUM_W-P_BITWIDTH+1){1'b0}}, {(P_BITWIDTH-1){1'b1}}} :
    {{(SUM_W-P_BITWIDTH){1'b0}}, {P_BITWIDTH{1'b1}}};
  localparam logic signed [SUM_W-1:0] P_MIN = (SIGNED != 0) ?
    {{(SUM_W-P_BITWIDTH+1){1'b1}}, {(P_BITWIDTH-1){1'b0}}} :
    {SUM_W{1'b0}};

  function automatic logic ovf_p(input logic signed [SUM_W-1:0] v);
    return (v > P_MAX) || (v < P_MIN);
  endfunction

  function automatic logic [P_BITWIDTH-1:0] clamp_p(input logic signed [SUM_W-1:0] v);
    if (v > P_MAX) return P_MAX[P_BITWIDTH-1:0];
    if (v < P_MIN) return P_MIN[P_BITWIDTH-1:0];
    return v[P_BITWIDTH-1:0];
  endfunction
`endif

  mac_vec_dot #(
    .LANES      (LANES),
    .A_BITWIDTH (A_BITWIDTH),
    .W_BITWIDTH (W_BITWIDTH),
    .SUM_W      (SUM_W),
    .SIGNED     (SIGNED)
  ) u_dot (
    .a_vec (A_in),
    .w_vec (w_active),
    .dot   (dot_sum)
  );

  if (SIGNED != 0) begin : g_pext_s
    assign p_ext = SUM_W'($signed(P_in));
  end else begin : g_pext_u
    assign p_ext = SUM_W'(P_in);
  end

  assign total = p_ext + dot_sum;

`ifdef MAC_VEC_PE_SAT_EN
  assign p_next = clamp_p(total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (A_en && ovf_p(total)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign p_next   = total[P_BITWIDTH-1:0];
  assign sat_flag = 1'b0;
`endif

  // Shadow load and swap control; a swap and a shadow write never share an edge
  // because writes require shadow_full=0 and swaps require shadow_full=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SWAP_IDLE;
      lane_cnt    <= '0;
      shadow_full <= 1'b0;
      w_shadow    <= '0;
      w_active    <= '0;
      switch_out  <= 1'b0;
    end else begin
      switch_out <= 1'b0;
      if (W_en && !shadow_full) begin
        w_shadow[lane_cnt*W_BITWIDTH +: W_BITWIDTH] <= W_in;
        if (lane_cnt == LAST_LANE) begin
          lane_cnt    <= '0;
          shadow_full <= 1'b1;
        end else begin
          lane_cnt <= lane_cnt + CNT_W'(1);
        end
      end
      case (state)
        SWAP_IDLE: begin
          if (switch_in) begin
            if (shadow_full) begin
              w_active    <= w_shadow;
              shadow_full <= 1'b0;
              switch_out  <= 1'b1;
            end else begin
              state <= SWAP_PENDING;
            end
          end
        end
        SWAP_PENDING: begin
          if (shadow_full) begin
            w_active    <= w_shadow;
            shadow_full <= 1'b0;
            switch_out  <= 1'b1;
            state       <= SWAP_IDLE;
          end
        end
        default: state <= SWAP_IDLE;
      endcase
    end
  end

  // Output stage: one-cycle forwarding of weights and activations plus the MAC result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_out   <= '0;
      W_ready <= 1'b0;
      A_out   <= '0;
      A_ready <= 1'b0;
      P_out   <= '0;
    end else begin
      W_out   <= W_in;
      W_ready <= W_en;
      A_ready <= A_en;
      if (A_en) begin
        A_out <= A_in;
        P_out <= p_next;
      end
    end
  end

endmodule
